// File: rtl/sha256_padder.sv
// sha256_padder: pads a 32-bit big-endian word stream into 512-bit SHA-256 blocks
// and paces them to the core using its block-completion pulse.
module sha256_padder #(
  parameter int LEN_W = 64
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic [31:0]  data_i,
  input  logic         data_vld_i,
  input  logic         data_last_i,
  input  logic [1:0]   data_bytes_i,
  output logic         data_rdy_o,
  output logic [511:0] blk_o,
  output logic         blk_vld_o,
  output logic         blk_last_o,
  input  logic         hash_vld_i,
  output logic         digest_vld_o
);
  typedef enum logic [1:0] {COLLECT, EMIT, WAIT_HASH, PAD} state_t;
  state_t state, state_n;
  logic [511:0] wbuf, wbuf_n, pblk;
  logic [3:0] idx;
  logic [LEN_W-1:0] len, len_n;
  logic pad_pend, mk_placed;
  logic [2:0] nb;
  logic [6:0] bcnt;
  logic [31:0] msk, mrk, wd;
  logic [63:0] len64, lenq64;
  logic full4, fits, blk_done, fin;
  assign nb = data_bytes_i == 2'd0 ? 3'd4 : {1'b0, data_bytes_i};
  assign full4 = data_last_i && data_bytes_i == 2'd0;
  assign bcnt = {1'b0, idx, 2'b0} + 7'(nb);
  assign fits = bcnt <= 7'd55;
  assign blk_done = data_last_i || idx == 4'd15;
  assign fin = state == WAIT_HASH && hash_vld_i && blk_last_o;
  assign len_n = len + (data_last_i ? LEN_W'({nb, 3'b0}) : LEN_W'(32));
  assign len64 = 64'(len_n);
  assign lenq64 = 64'(len);
  // invalid trailing bytes are zeroed and the marker lands right after the last valid byte
  assign msk = data_bytes_i == 2'd1 ? 32'hff000000 : data_bytes_i == 2'd2 ? 32'hffff0000 :
               data_bytes_i == 2'd3 ? 32'hffffff00 : 32'hffffffff;
  assign mrk = data_bytes_i == 2'd1 ? 32'h00800000 : data_bytes_i == 2'd2 ? 32'h00008000 :
               data_bytes_i == 2'd3 ? 32'h00000080 : 32'h0;
  assign wd = data_last_i ? (data_i & msk) | mrk : data_i;
  assign pblk = {lenq64[31:0], lenq64[63:32], 416'd0, mk_placed ? 32'h0 : 32'h80000000};
  always_comb begin
    wbuf_n = wbuf;
    wbuf_n[{idx, 5'b0} +: 32] = wd;
    if (full4 && idx != 4'd15) wbuf_n[{idx + 4'd1, 5'b0} +: 32] = 32'h80000000;
    if (data_last_i && fits) wbuf_n[511:448] = {len64[31:0], len64[63:32]};
  end
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state <= COLLECT;
    else state <= state_n;
  end
  always_comb begin
    state_n = state;
    case (state)
      COLLECT:   state_n = data_vld_i && blk_done ? EMIT : COLLECT;
      EMIT:      state_n = WAIT_HASH;
      WAIT_HASH: state_n = !hash_vld_i ? WAIT_HASH : (!blk_last_o && pad_pend) ? PAD : COLLECT;
      PAD:       state_n = EMIT;
      default:   state_n = COLLECT;
    endcase
  end
  always_comb begin
    data_rdy_o = rstn_i && state == COLLECT;
    blk_vld_o = state == EMIT;
  end
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wbuf <= '0;
      blk_o <= '0;
      idx <= '0;
      len <= '0;
      pad_pend <= 1'b0;
      mk_placed <= 1'b0;
      blk_last_o <= 1'b0;
      digest_vld_o <= 1'b0;
    end else begin
      digest_vld_o <= fin;
      if (state == COLLECT && data_vld_i) begin
        len <= len_n;
        if (blk_done) begin
          blk_o <= wbuf_n;
          wbuf <= '0;
          idx <= '0;
          blk_last_o <= data_last_i && fits;
          pad_pend <= data_last_i && !fits;
          mk_placed <= !(full4 && idx == 4'd15);
        end else begin
          wbuf <= wbuf_n;
          idx <= idx + 4'd1;
        end
      end
      if (state == PAD) begin
        blk_o <= pblk;
        blk_last_o <= 1'b1;
        pad_pend <= 1'b0;
      end
      if (fin) begin
        len <= '0;
        blk_last_o <= 1'b0;
        blk_o <= '0;
      end
    end
  end
endmodule

// File: tb/tb_sha256_padder.sv
// tb_sha256_padder: directed padding vectors checked by a block scoreboard,
// with a simple core model that answers each block with a hash_vld_i pulse.
module tb_sha256_padder;
  logic clk_i = 1'b0;
  logic rstn_i = 1'b0;
  logic [31:0] data_i = '0;
  logic data_vld_i = 1'b0;
  logic data_last_i = 1'b0;
  logic [1:0] data_bytes_i = '0;
  logic data_rdy_o;
  logic [511:0] blk_o;
  logic blk_vld_o;
  logic blk_last_o;
  logic hash_vld_i = 1'b0;
  logic digest_vld_o;
  int total = 0;
  int bad = 0;
  int dig = 0;
  int dig_exp = 0;
  logic last_popped = 1'b0;
  logic [511:0] eq_blk[$];
  logic eq_last[$];
  logic [511:0] b1, b2;
  logic [31:0] w;

  sha256_padder #(.LEN_W(64)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .data_i(data_i), .data_vld_i(data_vld_i),
    .data_last_i(data_last_i), .data_bytes_i(data_bytes_i), .data_rdy_o(data_rdy_o),
    .blk_o(blk_o), .blk_vld_o(blk_vld_o), .blk_last_o(blk_last_o),
    .hash_vld_i(hash_vld_i), .digest_vld_o(digest_vld_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] pw(input int i);
    return {8'(4 * i), 8'(4 * i + 1), 8'(4 * i + 2), 8'(4 * i + 3)};
  endfunction

  task automatic push(input logic [511:0] b, input logic l);
    eq_blk.push_back(b);
    eq_last.push_back(l);
  endtask

  task automatic send(input logic [31:0] d, input logic l, input logic [1:0] nbytes);
    int t = 0;
    data_i = d;
    data_last_i = l;
    data_bytes_i = nbytes;
    data_vld_i = 1'b1;
    while (!data_rdy_o && t < 200) begin
      @(negedge clk_i);
      t++;
    end
    if (t >= 200) chk("rdy_timeout", 512'(t), 512'(0));
    @(negedge clk_i);
  endtask

  task automatic chk_zero_outputs(input string nm);
    chk({nm, "_rdy"}, 512'(data_rdy_o), 512'(0));
    chk({nm, "_vld"}, 512'(blk_vld_o), 512'(0));
    chk({nm, "_last"}, 512'(blk_last_o), 512'(0));
    chk({nm, "_dig"}, 512'(digest_vld_o), 512'(0));
    chk({nm, "_blk"}, blk_o, 512'(0));
  endtask

  task automatic do_reset();
    data_vld_i = 1'b0;
    rstn_i = 1'b0;
    repeat (2) @(negedge clk_i);
    chk_zero_outputs("reset");
    rstn_i = 1'b1;
    @(negedge clk_i);
    chk("rdy_after_reset", 512'(data_rdy_o), 512'(1));
  endtask

  task automatic wait_digest(input string nm);
    int t = 0;
    dig_exp++;
    while (dig < dig_exp && t < 400) begin
      @(negedge clk_i);
      t++;
    end
    repeat (8) @(negedge clk_i);
    chk({nm, "_digests"}, 512'(dig), 512'(dig_exp));
    chk({nm, "_blocks_left"}, 512'(eq_blk.size()), 512'(0));
  endtask

  // scoreboard monitor
  always @(negedge clk_i) begin
    if (digest_vld_o) dig++;
    if (rstn_i && blk_vld_o) begin
      if (eq_blk.size() == 0) begin
        chk("unexpected_blk", blk_o, 512'(0));
        chk("unexpected_blk_vld", 512'(blk_vld_o), 512'(0));
      end else begin
        last_popped = eq_last.pop_front();
        chk("blk", blk_o, eq_blk.pop_front());
        chk("blk_last", 512'(blk_last_o), 512'(last_popped));
        chk("rdy_in_emit", 512'(data_rdy_o), 512'(0));
      end
    end
  end

  // core model: a few cycles of work, then one completion pulse
  initial begin
    forever begin
      @(negedge clk_i);
      if (rstn_i && blk_vld_o) begin
        repeat (4) begin
          @(negedge clk_i);
          chk("rdy_while_hashing", 512'(data_rdy_o), 512'(0));
        end
        hash_vld_i = 1'b1;
        @(negedge clk_i);
        hash_vld_i = 1'b0;
        chk("digest_timing", 512'(digest_vld_o), 512'(last_popped));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    do_reset();
    // "abc" with a nonzero invalid byte that must be masked
    b1 = '0;
    b1[31:0] = 32'h61626380;
    b1[511:480] = 32'h00000018;
    push(b1, 1'b1);
    send(32'h616263ff, 1'b1, 2'd3);
    data_vld_i = 1'b0;
    wait_digest("abc");
    // 55 bytes: single block
    do_reset();
    b1 = '0;
    for (int i = 0; i < 13; i++) b1[32 * i +: 32] = pw(i);
    w = pw(13);
    b1[32 * 13 +: 32] = {w[31:8], 8'h80};
    b1[511:480] = 32'h000001b8;
    push(b1, 1'b1);
    for (int i = 0; i < 13; i++) send(pw(i), 1'b0, 2'd0);
    send(pw(13), 1'b1, 2'd3);
    data_vld_i = 1'b0;
    wait_digest("len55");
    // 56 bytes: marker in block 1, length in block 2
    do_reset();
    b1 = '0;
    b2 = '0;
    for (int i = 0; i < 14; i++) b1[32 * i +: 32] = pw(i);
    b1[32 * 14 +: 32] = 32'h80000000;
    b2[511:480] = 32'h000001c0;
    push(b1, 1'b0);
    push(b2, 1'b1);
    for (int i = 0; i < 14; i++) send(pw(i), i == 13, 2'd0);
    data_vld_i = 1'b0;
    wait_digest("len56");
    // 61 bytes: marker in word 15 of block 1, pad block without marker
    do_reset();
    b1 = '0;
    b2 = '0;
    for (int i = 0; i < 15; i++) b1[32 * i +: 32] = pw(i);
    w = pw(15);
    b1[32 * 15 +: 32] = {w[31:24], 8'h80, 16'h0};
    b2[511:480] = 32'h000001e8;
    push(b1, 1'b0);
    push(b2, 1'b1);
    for (int i = 0; i < 15; i++) send(pw(i), 1'b0, 2'd0);
    send(pw(15), 1'b1, 2'd1);
    data_vld_i = 1'b0;
    wait_digest("len61");
    // 64 bytes: raw block then marker+length block
    do_reset();
    b1 = '0;
    b2 = '0;
    for (int i = 0; i < 16; i++) b1[32 * i +: 32] = pw(i);
    b2[31:0] = 32'h80000000;
    b2[511:480] = 32'h00000200;
    push(b1, 1'b0);
    push(b2, 1'b1);
    for (int i = 0; i < 16; i++) send(pw(i), i == 15, 2'd0);
    data_vld_i = 1'b0;
    wait_digest("len64");
    // 20 words with data_vld_i held high across the block boundary
    do_reset();
    b1 = '0;
    b2 = '0;
    for (int i = 0; i < 16; i++) b1[32 * i +: 32] = pw(i);
    for (int i = 0; i < 4; i++) b2[32 * i +: 32] = pw(16 + i);
    b2[32 * 4 +: 32] = 32'h80000000;
    b2[511:480] = 32'h00000280;
    push(b1, 1'b0);
    push(b2, 1'b1);
    for (int i = 0; i < 20; i++) send(pw(i), i == 19, 2'd0);
    data_vld_i = 1'b0;
    wait_digest("bp20");
    // reset mid-collect after 7 words, then "abc" again
    do_reset();
    for (int i = 0; i < 7; i++) send(pw(i), 1'b0, 2'd0);
    #3 rstn_i = 1'b0;
    #1 chk_zero_outputs("midreset");
    data_vld_i = 1'b0;
    @(negedge clk_i);
    rstn_i = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("midreset_no_digest", 512'(dig), 512'(dig_exp));
    b1 = '0;
    b1[31:0] = 32'h61626380;
    b1[511:480] = 32'h00000018;
    push(b1, 1'b1);
    send(32'h61626300, 1'b1, 2'd3);
    data_vld_i = 1'b0;
    wait_digest("abc_after_reset");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sha256_padder.md
Name: sha256_padder

Overview:
Front-end stage feeding the sha256 core. Accepts a message as a stream of 32-bit big-endian words and applies SHA-256 padding (0x80 marker, zero fill, 64-bit bit-length). Packs the result into 512-bit blocks and hands each block to the core on message_blk_i/message_blk_vld_i. Throttles itself on the core's hash_vld_o, because the core has no ready signal and must finish one block before the next is presented.

Parameters:
LEN_W, 64, width of the internal bit-length counter; values are zero-extended to 64 bits in the length field; legal range 32..64.

Ports:
clk_i  in  1  clock
rstn_i  in  1  asynchronous active-low reset
data_i  in  32  message word; first byte of the word in bits [31:24]
data_vld_i  in  1  data_i valid; transfer occurs when data_vld_i && data_rdy_o
data_last_i  in  1  qualifies the final word of the message
data_bytes_i  in  2  valid bytes in the final word, left-justified; 0 means 4; ignored unless data_last_i
data_rdy_o  out  1  padder can accept a word this cycle
blk_o  out  512  block to core; word k (k=0..15) at bits [32k+31:32k]
blk_vld_o  out  1  one-cycle pulse; drives the core's message_blk_vld_i
blk_last_o  out  1  current or most recent block is the final block of the message
hash_vld_i  in  1  core's hash_vld_o (block completion pulse)
digest_vld_o  out  1  one-cycle pulse: core digest for the full message is now valid

Behaviour:
- Reset values: all outputs 0; blk_o 0; FSM = COLLECT; word index 0; length counter 0.
- FSM states:
  - COLLECT: data_rdy_o=1. Each accepted word is written to word[idx]; idx increments; length += 32 bits.
    - Last word with n valid bytes (n = 1..4): length += 8n instead of 32. Invalid trailing bytes are forced to 0.
    - The 0x80 marker goes in the byte immediately after the last valid byte. If n=4, it goes in byte 0 of word[idx+1].
    - Words after the marker are zero-filled.
  - EMIT: blk_vld_o=1 for exactly one cycle with blk_o stable; next state WAIT_HASH. blk_o holds until the next EMIT.
  - WAIT_HASH: data_rdy_o=0. On hash_vld_i:
    - if last block was emitted: pulse digest_vld_o and return to COLLECT, with idx, length, blk_last_o and block cleared;
    - else if a pad block is pending: go to PAD;
    - else: go to COLLECT.
  - PAD: builds the extra all-padding block (word0 = 0x80000000 if the marker is not yet placed, else 0; words 1..13 = 0; length in words 14..15); then go to EMIT with blk_last_o=1.
- Block completion:
  - 16 words accepted without last: go to EMIT as a non-final block.
  - Last word accepted: message bytes in the block, plus the marker, ≤ 56: write length (word14 = len[63:32], word15 = len[31:0]) and go to EMIT with blk_last_o=1.
  - Otherwise: emit the current block (marker included if it fits) and set pad-pending.
- Byte counts in the final block: 0..55 message bytes give one block; 56..63 bytes give two blocks (marker in the first, length in the second); exactly 64 bytes give two blocks (marker in the second).
- Length arithmetic is modulo 2^LEN_W. Messages of zero bytes are not supported; every message has at least one word.
- hash_vld_i outside WAIT_HASH is ignored.
- data_vld_i with data_rdy_o low is not consumed. The source must hold data_i until the handshake completes.
- Reset mid-operation: asynchronously returns to the reset state. Any partial block is discarded and no blk_vld_o is issued. The core shares rstn_i, so its chaining state restarts too.
- The core accumulates chaining values across messages and has no per-message init. A new message after digest_vld_o is valid only if rstn_i is pulsed before it; this is the system controller's responsibility.
- Latency: last accepted word to blk_vld_o is 1 cycle; PAD to blk_vld_o is 1 cycle.

Test Plan:
- "abc": one word 0x61626300, last, bytes=3 -> one block: word0=0x61626380, words1..14=0, word15=0x00000018, blk_last_o=1. Core digest ba7816bf…f20015ad; digest_vld_o pulses 1 cycle after hash_vld_i.
- 55-byte message (13 full words + last word bytes=3) -> single block with word13 byte3=0x80 and word15=0x000001B8.
- 56-byte message (14 words, last bytes=4) -> block 1: word14=0x80000000, word15=0. Block 2: words0..14=0, word15=0x000001C0, blk_last_o=1.
- 64-byte message -> block 1 holds the raw data. Block 2: word0=0x80000000, word15=0x00000200. Exactly two blk_vld_o pulses.
- Backpressure: hold data_vld_i high through a 20-word message -> data_rdy_o is low from EMIT until hash_vld_i, no word is lost or duplicated, and the digest is correct.
- Reset asserted mid-COLLECT after 7 words -> no blk_vld_o, all outputs 0; a subsequent "abc" message produces the correct digest.
